// File: rtl/multicycle_controller.sv
`timescale 1ns/1ps
// Multicycle RV32 subset control FSM: Moore state decode plus combinational ALU/imm decode.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles per instruction with memory always ready.
// Backpressure: mem_ready low holds FETCH/MEMREAD/MEMWRITE (MemWrite stays asserted).
module multicycle_controller #(
    parameter int unsigned USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_t     state_q, state_d;
    logic       mem_rdy;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;

    assign mem_rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
    assign state   = state_q;
    assign PCWrite = pc_update | (branch & Zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = FETCH;
        pc_update = 1'b0;
        branch    = 1'b0;
        alu_op    = 2'b00;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_rdy;
                pc_update = mem_rdy;
                state_d   = mem_rdy ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXECUTER;
                    OP_I:              state_d = EXECUTEI;
                    OP_JAL:            state_d = JAL;
                    OP_BEQ:            state_d = BEQ;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                // strobe held through the stall so the memory sees a stable request
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_rdy ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: RegWrite = 1'b1;
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE: ImmSrc = 2'b01;
            OP_BEQ:   ImmSrc = 2'b10;
            OP_JAL:   ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
// Bench for multicycle_controller: decode table, hand-built stall/reset sequences,
// and random instruction streams against a per-instruction expected-trace model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.USE_MEM_READY(1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal(illegal), .state(state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One instruction per row, memory always ready; "cycle 2" is the state after DECODE.
    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         lat;
        logic [3:0] st2;
        logic [2:0] ac2;
        logic       pcw2;
        logic [1:0] imm2;
        logic       ill1;
    } vec_t;

    typedef struct {
        logic       mr;
        logic [3:0] st;
        logic       rw;
        logic       mw;
        logic       il;
    } exp_t;

    vec_t vecs[13];
    exp_t q[$];

    function automatic void push(input logic mr, input int st, input logic rw,
                                 input logic mw, input logic il);
        exp_t e;
        e.mr = mr; e.st = 4'(st); e.rw = rw; e.mw = mw; e.il = il;
        q.push_back(e);
    endfunction

    // Expected per-cycle trace of one instruction: class 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq, 6 illegal.
    function automatic void build(input int cls, input int sf, input int sm);
        q.delete();
        for (int s = 0; s < sf; s++) push(1'b0, 0, 1'b0, 1'b0, 1'b0);
        push(1'b1, 0, 1'b0, 1'b0, 1'b0);
        push(1'($urandom), 1, 1'b0, 1'b0, cls == 6);
        case (cls)
            0: begin
                push(1'($urandom), 2, 1'b0, 1'b0, 1'b0);
                for (int s = 0; s < sm; s++) push(1'b0, 3, 1'b0, 1'b0, 1'b0);
                push(1'b1, 3, 1'b0, 1'b0, 1'b0);
                push(1'($urandom), 4, 1'b1, 1'b0, 1'b0);
            end
            1: begin
                push(1'($urandom), 2, 1'b0, 1'b0, 1'b0);
                for (int s = 0; s < sm; s++) push(1'b0, 5, 1'b0, 1'b1, 1'b0);
                push(1'b1, 5, 1'b0, 1'b1, 1'b0);
            end
            2, 3, 4: begin
                push(1'($urandom), (cls == 2) ? 6 : (cls == 3) ? 8 : 9, 1'b0, 1'b0, 1'b0);
                push(1'($urandom), 7, 1'b1, 1'b0, 1'b0);
            end
            5: push(1'($urandom), 10, 1'b0, 1'b0, 1'b0);
            default: ;
        endcase
    endfunction

    function automatic logic [6:0] op_for(input int cls);
        logic [6:0] r;
        case (cls)
            0: r = 7'b0000011;
            1: r = 7'b0100011;
            2: r = 7'b0110011;
            3: r = 7'b0010011;
            4: r = 7'b1101111;
            5: r = 7'b1100011;
            default: begin
                r = 7'($urandom_range(0, 127));
                if (r == 7'b0000011 || r == 7'b0100011 || r == 7'b0110011 ||
                    r == 7'b0010011 || r == 7'b1101111 || r == 7'b1100011) r = 7'b0000000;
            end
        endcase
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int mw_count;
        int exp_lw[6];
        int cls;

        vecs[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 4'd2,  3'b000, 1'b0, 2'b00, 1'b0};
        vecs[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 4'd2,  3'b000, 1'b0, 2'b01, 1'b0};
        vecs[2]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 4'd6,  3'b000, 1'b0, 2'b00, 1'b0};
        vecs[3]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 4'd6,  3'b001, 1'b0, 2'b00, 1'b0};
        vecs[4]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 4'd6,  3'b101, 1'b0, 2'b00, 1'b0};
        vecs[5]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 4'd6,  3'b011, 1'b0, 2'b00, 1'b0};
        vecs[6]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4, 4'd6,  3'b010, 1'b0, 2'b00, 1'b0};
        vecs[7]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 4'd8,  3'b000, 1'b0, 2'b00, 1'b0};
        vecs[8]  = '{7'b0110011, 3'b001, 1'b1, 1'b0, 4, 4'd6,  3'b000, 1'b0, 2'b00, 1'b0};
        vecs[9]  = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 4'd9,  3'b000, 1'b1, 2'b11, 1'b0};
        vecs[10] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 4'd10, 3'b001, 1'b1, 2'b10, 1'b0};
        vecs[11] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 4'd10, 3'b001, 1'b0, 2'b10, 1'b0};
        vecs[12] = '{7'b0000000, 3'b000, 1'b0, 1'b0, 2, 4'd0,  3'b000, 1'b1, 2'b00, 1'b1};

        rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_memwrite", 32'(MemWrite), 32'd0);
        check("reset_regwrite", 32'(RegWrite), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 13; i++) begin
            op = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7;
            Zero = vecs[i].zero; mem_ready = 1'b1;
            lat = 99;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                #1;
                if (k == 1) check($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill1));
                if (k == 2) begin
                    check($sformatf("vec%0d_state2", i), 32'(state), 32'(vecs[i].st2));
                    check($sformatf("vec%0d_aluctl", i), 32'(ALUControl), 32'(vecs[i].ac2));
                    check($sformatf("vec%0d_pcwrite", i), 32'(PCWrite), 32'(vecs[i].pcw2));
                    check($sformatf("vec%0d_immsrc", i), 32'(ImmSrc), 32'(vecs[i].imm2));
                end
                if (state == 4'd0) begin
                    lat = k;
                    break;
                end
            end
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // lw trace with RegWrite only in MEMWB
        exp_lw = '{0, 1, 2, 3, 4, 0};
        op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check($sformatf("lw_state%0d", k), 32'(state), 32'(exp_lw[k]));
            check($sformatf("lw_regwrite%0d", k), 32'(RegWrite), 32'(exp_lw[k] == 4));
            if (exp_lw[k] == 4) check("lw_resultsrc", 32'(ResultSrc), 32'd1);
        end

        // sw with three stall cycles in MEMWRITE
        op = 7'b0100011; mw_count = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            mem_ready = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
            #1;
            mw_count += int'(MemWrite);
            if (k == 7) check("sw_stall_end_state", 32'(state), 32'd0);
        end
        check("sw_stall_memwrite_cycles", 32'(mw_count), 32'd4);

        // asynchronous reset while stalled in MEMWRITE
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            mem_ready = (k == 3) ? 1'b0 : 1'b1;
            #1;
        end
        check("pre_reset_state", 32'(state), 32'd5);
        check("pre_reset_memwrite", 32'(MemWrite), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_memwrite", 32'(MemWrite), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("held_reset_state", 32'(state), 32'd0);
        rst_n = 1'b1; mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'b000;
        #1;
        check("release_state", 32'(state), 32'd0);
        @(negedge clk);
        #1;
        check("resume_state", 32'(state), 32'd1);
        lat = 99;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            if (state == 4'd0) begin
                lat = k;
                break;
            end
        end
        check("resume_finish", 32'(lat), 32'd3);

        // FETCH stall
        mem_ready = 1'b0;
        #1;
        check("fetch_stall_irwrite", 32'(IRWrite), 32'd0);
        check("fetch_stall_pcwrite", 32'(PCWrite), 32'd0);
        @(negedge clk);
        #1;
        check("fetch_stall_state", 32'(state), 32'd0);
        mem_ready = 1'b1;
        #1;
        check("fetch_ready_irwrite", 32'(IRWrite), 32'd1);

        // random instruction stream
        for (int n = 0; n < 80; n++) begin
            cls = $urandom_range(0, 6);
            op = op_for(cls);
            funct3 = 3'($urandom);
            funct7b5 = 1'($urandom);
            build(cls, $urandom_range(0, 2), $urandom_range(0, 3));
            foreach (q[j]) begin
                mem_ready = q[j].mr;
                Zero = 1'($urandom);
                #1;
                check($sformatf("rand%0d_cyc%0d st/rw/mw/il", n, j),
                      32'({state, RegWrite, MemWrite, illegal}),
                      32'({q[j].st, q[j].rw, q[j].mw, q[j].il}));
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter: USE_MEM_READY, 1, 1 = honour mem_ready stalls; 0 = treat mem_ready as constant 1.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; no other clock or reset.
REQ-003 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- op  in  7  instruction opcode
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut to memory address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = const 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state encoding (debug)

Function
REQ-004 SHALL implement a Moore FSM with states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10.
REQ-005 SHALL make all outputs except PCWrite, ImmSrc and ALUControl functions of state only; unlisted outputs are 0 in every state.
REQ-006 SHALL compute PCWrite = PCUpdate | (Branch & Zero) combinationally.
REQ-007 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=mem_ready; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-008 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1101111 -> JAL
- 1100011 -> BEQ
- any other value -> FETCH, with illegal=1 for that cycle
REQ-009 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
REQ-010 MEMREAD: AdrSrc=1, ResultSrc=00; hold while mem_ready=0, else go to MEMWB.
REQ-011 MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
REQ-012 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held through any stall; mem_ready=1 -> FETCH.
REQ-013 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
REQ-014 EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
REQ-015 ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-016 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
REQ-017 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
REQ-018 ImmSrc SHALL decode from op in every state: load/OP-IMM 00, store 01, branch 10, jal 11, other 00.
REQ-019 ALUControl SHALL decode combinationally:
- ALUOp 00 -> 000; ALUOp 01 -> 001
- ALUOp 10 with funct3 000 -> 001 if op[5]&funct7b5, else 000
- ALUOp 10 with funct3 010 -> 101; 110 -> 011; 111 -> 010
- ALUOp 10 with other funct3 -> 000
REQ-020 Unreachable state encodings 11-15 SHALL transition to FETCH with all strobes 0.
REQ-021 Instruction latency with mem_ready=1: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.

Reset
REQ-022 rst_n=0 SHALL force state=FETCH immediately (asynchronously), regardless of clk.
REQ-023 During reset, MemWrite, RegWrite and illegal SHALL be 0; FETCH decode still drives IRWrite=PCUpdate=mem_ready, which is harmless because datapath registers are also held in reset.
REQ-024 Reset asserted mid-instruction (e.g. in MEMWRITE) SHALL abort that instruction; fetch resumes on the first clk edge after rst_n deasserts.

Verification
REQ-025 lw (op=0000011), mem_ready=1: state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4, with ResultSrc=01.
REQ-026 sw, mem_ready low 3 cycles in MEMWRITE: MemWrite=1 for 4 consecutive cycles, then state=0.
REQ-027 beq: Zero=1 in BEQ gives PCWrite=1 and ALUControl=001; Zero=0 gives PCWrite=0.
REQ-028 R-type sub (funct3=000, funct7b5=1): ALUControl=001 in EXECUTER; addi with funct7b5=1 (op[5]=0) gives ALUControl=000.
REQ-029 op=0000000 in DECODE: illegal=1 for one cycle, then state=0; no RegWrite or MemWrite pulse.
REQ-030 rst_n low mid-MEMWRITE: state=0 and MemWrite=0 immediately, with no clk edge required.
